alu_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU (4-bit op, A, B -> Y) between two requesters with valid/ready handshakes.
- Round-robin grant; operands are latched, issued to the ALU for one cycle, and the registered result is returned to the granted requester with backpressure.
- Sits between two datapath clients (e.g. a main-pipe and a multi-cycle unit) and the shared ALU instance.

---
 rtl/alu_arbiter.sv | 157 +++++++++++++++
 tb/tb_alu_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//
// Requests are granted round-robin. The granted operands are latched,
// presented to the ALU for one cycle (ISSUE), and the registered result is
// then held for the owning requester until it takes it (RESP).
//
// Ports:
//   clk, reset_n              clock, synchronous active-low reset
//   req{0,1}_valid/ready      request handshake (ready combinational, IDLE only)
//   req{0,1}_op/_a/_b         request opcode and operands
//   alu_op/alu_a/alu_b        registered drive to the shared ALU
//   alu_y                     ALU result (combinational from alu_*)
//   rsp{0,1}_valid/ready      response handshake for each requester
//   rsp_y, rsp_zero, rsp_err  shared response data, zero flag, illegal-op flag
//
// Optional feature macro: ALU_OP_CHECK_EN
//   When defined, illegal opcodes bypass the ALU and return rsp_y=0,
//   rsp_zero=1, rsp_err=1. When undefined, every opcode is issued and
//   rsp_err is tied low.
//
// state | meaning
// IDLE  | waiting for a request; grants and accepts one
// ISSUE | latched op on alu_*; result captured at the edge
// RESP  | result held for owner until its rsp ready

module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic             rsp_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_grant;

    // Grants are mutually exclusive: on contention the requester that was
    // not served last wins.
    logic grant0, grant1;
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) &&  owner;

    logic [OPW-1:0]   sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    assign sel_op = grant1 ? req1_op : req0_op;
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;

    logic rsp_taken;
    assign rsp_taken = owner ? rsp1_ready : rsp0_ready;

`ifdef ALU_OP_CHECK_EN
    logic err_q;
    assign rsp_err = err_q;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        case (op)
            4'b0000, 4'b0010, 4'b0100, 4'b0101,
            4'b0110, 4'b0111, 4'b1010: op_legal = 1'b1;
            default:                   op_legal = 1'b0;
        endcase
    endfunction
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_y      <= '0;
            rsp_zero   <= 1'b0;
`ifdef ALU_OP_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        owner <= grant1;
`ifdef ALU_OP_CHECK_EN
                        if (!op_legal(sel_op)) begin
                            // alu_* deliberately left untouched
                            rsp_y    <= '0;
                            rsp_zero <= 1'b1;
                            err_q    <= 1'b1;
                            state    <= RESP;
                        end else begin
                            alu_op <= sel_op;
                            alu_a  <= sel_a;
                            alu_b  <= sel_b;
                            err_q  <= 1'b0;
                            state  <= ISSUE;
                        end
`else
                        alu_op <= sel_op;
                        alu_a  <= sel_a;
                        alu_b  <= sel_b;
                        state  <= ISSUE;
`endif
                    end
                end
                ISSUE: begin
                    rsp_y    <= alu_y;
                    rsp_zero <= (alu_y == '0);
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_taken) begin
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU.
// Stimulus pushes the expected response (owner, y, zero, err) when it issues
// a request; a monitor pops and compares at every response handshake.

module tb_alu_arbiter;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [OPW-1:0]   req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_zero, rsp_err;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // Shared ALU; unknown opcodes produce a recognisable pattern.
    always_comb begin
        case (alu_op)
            4'b0000: alu_y = alu_a + alu_b;
            4'b0010: alu_y = alu_a - alu_b;
            4'b0100: alu_y = alu_a & alu_b;
            4'b0101: alu_y = alu_a | alu_b;
            4'b0110: alu_y = alu_a ^ alu_b;
            4'b0111: alu_y = ~(alu_a | alu_b);
            4'b1010: alu_y = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_y = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct packed {
        logic        owner;
        logic [31:0] y;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic own, input logic [31:0] y, input logic zero, input logic err);
        exp_t e;
        e.owner = own; e.y = y; e.zero = zero; e.err = err;
        exp_q.push_back(e);
    endtask

    // Monitor: compares each delivered response against the scoreboard head.
    always @(negedge clk) begin
        if (reset_n) begin
            if (rsp0_valid && rsp1_valid)
                chk("both_rsp_valid", 32'd1, 32'd0);
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, rsp1_valid}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_owner", {31'd0, rsp1_valid}, {31'd0, e.owner});
                    chk("rsp_y",     rsp_y, e.y);
                    chk("rsp_zero",  {31'd0, rsp_zero}, {31'd0, e.zero});
                    chk("rsp_err",   {31'd0, rsp_err},  {31'd0, e.err});
                end
            end
        end
    end

    // Waits for the given requester's accept edge; returns 1 ns after it.
    task automatic wait_accept(input int n);
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            ok = (n == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
            @(posedge clk);
            #1;
        end
        if (!ok) chk($sformatf("accept_timeout_req%0d", n), 32'd0, 32'd1);
    endtask

    task automatic send(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (n == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        wait_accept(n);
        if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    task automatic wait_rsp0();
        for (int i = 0; i < 20 && !rsp0_valid; i++) @(negedge clk);
        chk("rsp0_valid_seen", {31'd0, rsp0_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] saved_op;
        int         grants[$];
        int         accepts;

        reset_n = 1'b0;
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req0_a = 0; req0_b = 0;
        req1_op = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp_y",      rsp_y, 32'd0);
        chk("rst_rsp_zero",   {31'd0, rsp_zero}, 32'd0);
        chk("rst_rsp_err",    {31'd0, rsp_err}, 32'd0);
        chk("rst_alu_op",     {28'd0, alu_op}, 32'd0);
        chk("rst_alu_a",      alu_a, 32'd0);
        chk("rst_alu_b",      alu_b, 32'd0);

        // ADD 5+7 on requester 0, with latency checks.
        push(1'b0, 32'd12, 1'b0, 1'b0);
        send(0, 4'b0000, 32'd5, 32'd7);
        chk("add_ready_pulse", {31'd0, req0_ready}, 32'd0);
        chk("add_rsp0_early",  {31'd0, rsp0_valid}, 32'd0);
        chk("add_alu_a",       alu_a, 32'd5);
        chk("add_alu_b",       alu_b, 32'd7);
        @(posedge clk); #1;
        chk("add_rsp0_valid",  {31'd0, rsp0_valid}, 32'd1);
        chk("add_rsp1_quiet",  {31'd0, rsp1_valid}, 32'd0);
        drain();

        // SUB 9-9 on requester 1 -> zero.
        push(1'b1, 32'd0, 1'b1, 1'b0);
        send(1, 4'b0010, 32'd9, 32'd9);
        drain();

        // Both valid continuously: grants alternate 0,1,0,1.
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 32'h00F0_00F0, 1'b0, 1'b0);
            push(1'b1, 32'hFFF0_FFF0, 1'b0, 1'b0);
        end
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b0100; req0_a = 32'hF0F0_F0F0; req0_b = 32'h0FF0_0FF0;
        req1_valid = 1; req1_op = 4'b0101; req1_a = 32'hF0F0_F0F0; req1_b = 32'h0FF0_0FF0;
        accepts = 0;
        for (int i = 0; i < 100 && accepts < 4; i++) begin
            bit a0, a1;
            #1;
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk);
            if (a0) begin grants.push_back(0); accepts++; end
            if (a1) begin grants.push_back(1); accepts++; end
            #1;
        end
        req0_valid = 0; req1_valid = 0;
        chk("alt_accept_count", grants.size(), 32'd4);
        for (int k = 0; k < grants.size() && k < 4; k++)
            chk($sformatf("alt_grant%0d", k), grants[k], k % 2);
        drain();

        // Backpressure: SLT -1<1 held while requester 1 waits.
        push(1'b0, 32'd1, 1'b0, 1'b0);
        push(1'b1, 32'd7, 1'b0, 1'b0);
        rsp0_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1; req0_op = 4'b1010; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1;
        req1_valid = 1; req1_op = 4'b0000; req1_a = 32'd3;         req1_b = 32'd4;
        wait_accept(0);
        req0_valid = 0;
        wait_rsp0();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            chk("bp_rsp_y",      rsp_y, 32'd1);
            chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
        end
        rsp0_ready = 1'b1;
        wait_accept(1);
        req1_valid = 0;
        drain();

        // Reset during RESP discards the pending op.
        rsp0_ready = 1'b0;
        push(1'b0, 32'd2, 1'b0, 1'b0);
        send(0, 4'b0000, 32'd1, 32'd1);
        wait_rsp0();
        @(negedge clk); reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        void'(exp_q.pop_back());
        #1;
        chk("rstmid_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rstmid_rsp_y",      rsp_y, 32'd0);
        @(posedge clk); #1;
        chk("rstmid_next_rsp0",  {31'd0, rsp0_valid}, 32'd0);
        chk("rstmid_next_rsp1",  {31'd0, rsp1_valid}, 32'd0);
        rsp0_ready = 1'b1;
        push(1'b1, 32'hF00F_F00F, 1'b0, 1'b0);
        send(1, 4'b0110, 32'hFF00_FF00, 32'h0F0F_0F0F);
        drain();

        // Illegal opcode 1111.
        saved_op = alu_op;
`ifdef ALU_OP_CHECK_EN
        push(1'b0, 32'd0, 1'b1, 1'b1);
        send(0, 4'b1111, 32'd5, 32'd6);
        chk("illegal_alu_op_kept", {28'd0, alu_op}, {28'd0, saved_op});
        chk("illegal_direct_resp", {31'd0, rsp0_valid}, 32'd1);
`else
        push(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        send(0, 4'b1111, 32'd5, 32'd6);
        chk("illegal_alu_op_issued", {28'd0, alu_op}, 32'hF);
        chk("illegal_alu_a_issued",  alu_a, 32'd5);
`endif
        drain();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
